// File: rtl/trotrig_ctrl_pkg.sv
// Shared types and constants for the trotrig capture sequencer.
package trotrig_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREFILL,
        ST_ARMED,
        ST_POST,
        ST_READOUT
    } ctrl_state_t;

    localparam int RD_LATENCY     = 1;
    localparam int TOBITS_DEFAULT = 16;

endpackage

// File: rtl/trotrig_capture_ctrl_if.sv
// Show-ahead readout stream; master side is the capture controller.
interface trotrig_capture_ctrl_if #(
    parameter int DINBITS = 8
);
    logic               rd_valid;
    logic               rd_ready;
    logic [DINBITS-1:0] rd_data;
    logic               rd_last;

    modport master (output rd_valid, output rd_data, output rd_last, input rd_ready);
    modport slave  (input rd_valid, input rd_data, input rd_last, output rd_ready);
endinterface

// File: rtl/trotrig_capture_ram.sv
// Simple dual-port capture buffer: synchronous write, registered read with enable.
module trotrig_capture_ram #(
    parameter int DINBITS = 8,
    parameter int ABITS   = 6
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ABITS-1:0]   waddr,
    input  logic [DINBITS-1:0] wdata,
    input  logic               re,
    input  logic [ABITS-1:0]   raddr,
    output logic [DINBITS-1:0] rdata
);
    logic [DINBITS-1:0] mem [2**ABITS];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/trotrig_capture_ctrl.sv
// Capture sequencer for trotrig: circular pre/post-trigger capture and oldest-first readout.
// Optional ARMED-state timeout is enabled with `define TROTRIG_CTRL_TIMEOUT_EN.
module trotrig_capture_ctrl
    import trotrig_ctrl_pkg::*;
#(
    parameter int DINBITS = 8,
    parameter int ABITS   = 6
`ifdef TROTRIG_CTRL_TIMEOUT_EN
    ,
    parameter int TOBITS  = TOBITS_DEFAULT
`endif
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               arm,
    input  logic               abort,
    input  logic               enable,
    input  logic [DINBITS-1:0] din,
    input  logic [ABITS-1:0]   post_count,
    input  logic               trigger,
    output logic               trig_reset,
    output logic               busy,
    output logic               done,
    trotrig_capture_ctrl_if.master rd
`ifdef TROTRIG_CTRL_TIMEOUT_EN
    ,
    output logic               timeout
`endif
);
    localparam logic [ABITS:0]   DEPTH_W = (ABITS+1)'(2**ABITS);
    localparam logic [ABITS:0]   ONE_W   = (ABITS+1)'(1);
    localparam logic [ABITS-1:0] ONE_A   = ABITS'(1);

    ctrl_state_t        state, state_next;
    logic [ABITS-1:0]   wptr, post, remain, raddr;
    logic [ABITS:0]     fill, rd_cnt;
    logic               we, ren, q_vld, q_last, out_load, hs, prefill_done, to_expired;
    logic [DINBITS-1:0] ram_q;

    assign prefill_done = (fill + ONE_W) == (DEPTH_W - {1'b0, post});
    assign hs           = rd.rd_valid && rd.rd_ready;
    assign busy         = (state != ST_IDLE);
    assign trig_reset   = (state != ST_ARMED);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        we         = 1'b0;
        case (state)
            ST_IDLE:    if (arm) state_next = ST_PREFILL;
            ST_PREFILL: begin
                we = enable;
                if (enable && prefill_done) state_next = ST_ARMED;
            end
            ST_ARMED: begin
                we = enable;
                if (trigger)         state_next = ST_POST;
                else if (to_expired) state_next = ST_READOUT;
            end
            ST_POST: begin
                // A zero post count leaves POST immediately without writing
                if (remain == '0) state_next = ST_READOUT;
                else begin
                    we = enable;
                    if (enable && remain == ONE_A) state_next = ST_READOUT;
                end
            end
            ST_READOUT: if (hs && rd.rd_last) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
        if (abort) begin
            state_next = ST_IDLE;
            we         = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr   <= '0;
            fill   <= '0;
            post   <= '0;
            remain <= '0;
            done   <= 1'b0;
        end else begin
            done <= (state == ST_READOUT) && hs && rd.rd_last && !abort;
            if (state == ST_IDLE && arm && !abort) begin
                wptr <= '0;
                fill <= '0;
                post <= post_count;
            end else if (we) begin
                wptr <= wptr + ONE_A;
                fill <= fill + ONE_W;
            end
            if (state == ST_ARMED && trigger)  remain <= post;
            else if (state == ST_POST && we)   remain <= remain - ONE_A;
        end
    end

`ifdef TROTRIG_CTRL_TIMEOUT_EN
    localparam logic [TOBITS-1:0] TO_ONE = TOBITS'(1);
    logic [TOBITS-1:0] to_cnt;

    assign to_expired = (state == ST_ARMED) && (to_cnt == '1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            to_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (state == ST_ARMED && !trigger) to_cnt <= to_cnt + TO_ONE;
            else                               to_cnt <= '0;
            if (state == ST_IDLE && arm && !abort)       timeout <= 1'b0;
            else if (to_expired && !trigger && !abort)   timeout <= 1'b1;
        end
    end
`else
    assign to_expired = 1'b0;
`endif

    // Oldest entry sits at the final write pointer, so reads walk forward from there
    assign raddr    = wptr + rd_cnt[ABITS-1:0];
    assign out_load = q_vld && (!rd.rd_valid || rd.rd_ready);
    assign ren      = (state == ST_READOUT) && !rd_cnt[ABITS] && (!q_vld || out_load);

    trotrig_capture_ram #(
        .DINBITS (DINBITS),
        .ABITS   (ABITS)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wptr),
        .wdata (din),
        .re    (ren),
        .raddr (raddr),
        .rdata (ram_q)
    );

    // RAM output register plus output register form a two-deep show-ahead pipeline
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_cnt      <= '0;
            q_vld       <= 1'b0;
            q_last      <= 1'b0;
            rd.rd_valid <= 1'b0;
            rd.rd_last  <= 1'b0;
            rd.rd_data  <= '0;
        end else if (abort || state != ST_READOUT) begin
            rd_cnt      <= '0;
            q_vld       <= 1'b0;
            q_last      <= 1'b0;
            rd.rd_valid <= 1'b0;
            rd.rd_last  <= 1'b0;
        end else begin
            if (ren) begin
                rd_cnt <= rd_cnt + ONE_W;
                q_last <= (rd_cnt == DEPTH_W - ONE_W);
            end
            if (ren)           q_vld <= 1'b1;
            else if (out_load) q_vld <= 1'b0;
            if (out_load) begin
                rd.rd_valid <= 1'b1;
                rd.rd_data  <= ram_q;
                rd.rd_last  <= q_last;
            end else if (rd.rd_ready) begin
                rd.rd_valid <= 1'b0;
                rd.rd_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_trotrig_capture_ctrl.sv
// Self-checking bench for trotrig_capture_ctrl (DEPTH 16) against a queue-based capture model.
// Timeout scenario is compiled in when TROTRIG_CTRL_TIMEOUT_EN is defined.
module tb_trotrig_capture_ctrl;
    localparam int DEPTH     = 16;
    localparam int TO_CYCLES = 16;
    localparam int P_IDLE = 0, P_PREFILL = 1, P_ARMED = 2, P_POST = 3, P_READOUT = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       arm = 1'b0, abort = 1'b0, enable = 1'b0, trigger = 1'b0;
    logic [7:0] din = 8'h00;
    logic [3:0] post_count = 4'd0;
    logic       trig_reset, busy, done;
`ifdef TROTRIG_CTRL_TIMEOUT_EN
    logic       timeout;
`endif

    int checks = 0;
    int failures = 0;

    int         m_phase = P_IDLE;
    int         m_post, m_fill, m_remain, m_armed_cycles;
    logic [7:0] m_hist[$];

    always #5 clk = ~clk;

    trotrig_capture_ctrl_if #(.DINBITS(8)) rd_if ();

    trotrig_capture_ctrl #(
        .DINBITS (8),
        .ABITS   (4)
`ifdef TROTRIG_CTRL_TIMEOUT_EN
        ,
        .TOBITS  (4)
`endif
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .arm        (arm),
        .abort      (abort),
        .enable     (enable),
        .din        (din),
        .post_count (post_count),
        .trigger    (trigger),
        .trig_reset (trig_reset),
        .busy       (busy),
        .done       (done),
        .rd         (rd_if)
`ifdef TROTRIG_CTRL_TIMEOUT_EN
        ,
        .timeout    (timeout)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Capture rules applied to the inputs seen at one clock edge
    task automatic modelStep();
        if (!resetn || abort) begin
            m_phase = P_IDLE;
            return;
        end
        case (m_phase)
            P_IDLE: if (arm) begin
                m_hist.delete();
                m_post  = int'(post_count);
                m_fill  = 0;
                m_phase = P_PREFILL;
            end
            P_PREFILL: if (enable) begin
                m_hist.push_back(din);
                m_fill++;
                if (m_fill == DEPTH - m_post) begin
                    m_phase = P_ARMED;
                    m_armed_cycles = 0;
                end
            end
            P_ARMED: begin
                if (enable) m_hist.push_back(din);
                if (trigger) begin
                    m_phase  = P_POST;
                    m_remain = m_post;
                end else begin
                    m_armed_cycles++;
`ifdef TROTRIG_CTRL_TIMEOUT_EN
                    if (m_armed_cycles == TO_CYCLES) m_phase = P_READOUT;
`endif
                end
            end
            P_POST: begin
                if (m_remain == 0) m_phase = P_READOUT;
                else if (enable) begin
                    m_hist.push_back(din);
                    m_remain--;
                    if (m_remain == 0) m_phase = P_READOUT;
                end
            end
            default: ;
        endcase
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, "_busy"},       busy,           m_phase != P_IDLE);
        checkOutput({tag, "_trig_reset"}, trig_reset,     m_phase != P_ARMED);
        checkOutput({tag, "_rd_valid"},   rd_if.rd_valid, 1'b0);
    endtask

    // One arm-to-done capture; ready_mode 0=always, 1=1,0,0,1 pattern, 2=random
    task automatic runCapture(input string tag, input int post_v, input int trig_delay,
                              input bit trig_hold, input int en_pct, input int ready_mode,
                              input bit abort_post, input int reset_beat,
                              output logic [7:0] first_data, output logic [7:0] last_data);
        int         pre_writes = 0, low_cycles = 0, guard = 0, beat = 0, cyc = 0, first_valid = -1;
        bit         seen_low = 0, held = 0;
        logic [7:0] held_data, exp_q[$];
        logic       held_last;
        first_data = 8'hxx;
        last_data  = 8'hxx;
        din = 8'h00;
        post_count = 4'(post_v);
        arm = 1'b1;
        enable = 1'b1;
        trigger = trig_hold;
        rd_if.rd_ready = 1'b1;
        applyStimulus();
        arm = 1'b0;
        checkOutput({tag, "_busy_after_arm"}, busy, 1'b1);
`ifdef TROTRIG_CTRL_TIMEOUT_EN
        checkOutput({tag, "_timeout_cleared"}, timeout, 1'b0);
`endif
        while (m_phase != P_READOUT && m_phase != P_IDLE && guard < 2000) begin
            din = din + 8'd1;
            enable = ($urandom_range(99) < en_pct);
            trigger = trig_hold || (m_phase == P_ARMED && m_armed_cycles >= trig_delay);
            abort = abort_post && (m_phase == P_POST);
            if (trig_reset === 1'b1 && !seen_low && enable) pre_writes++;
            if (trig_reset === 1'b0) begin
                seen_low = 1;
                low_cycles++;
            end
            applyStimulus();
            guard++;
            checkState(tag);
        end
        abort = 1'b0;
        trigger = 1'b0;
        checkOutput({tag, "_capture_bound"}, guard < 2000, 1'b1);
        checkOutput({tag, "_prefill_writes"}, pre_writes, DEPTH - post_v);
        if (trig_hold) checkOutput({tag, "_armed_cycles"}, low_cycles, 1);
`ifdef TROTRIG_CTRL_TIMEOUT_EN
        if (trig_delay >= TO_CYCLES) begin
            checkOutput({tag, "_armed_to_timeout"}, low_cycles, TO_CYCLES);
            checkOutput({tag, "_timeout_flag"}, timeout, 1'b1);
        end
`endif
        if (m_phase != P_READOUT) return;

        for (int i = 0; i < DEPTH; i++) exp_q.push_back(m_hist[m_hist.size() - DEPTH + i]);
        while (beat < DEPTH && cyc < 400) begin
            if (reset_beat > 0 && beat >= reset_beat) begin
                resetn = 1'b0;
                #1;
                checkOutput({tag, "_rst_busy"},       busy,           1'b0);
                checkOutput({tag, "_rst_trig_reset"}, trig_reset,     1'b1);
                checkOutput({tag, "_rst_rd_valid"},   rd_if.rd_valid, 1'b0);
                checkOutput({tag, "_rst_rd_last"},    rd_if.rd_last,  1'b0);
                checkOutput({tag, "_rst_rd_data"},    rd_if.rd_data,  8'h00);
                checkOutput({tag, "_rst_done"},       done,           1'b0);
                applyStimulus();
                applyStimulus();
                resetn = 1'b1;
                return;
            end
            rd_if.rd_ready = (ready_mode == 0) ? 1'b1 :
                             (ready_mode == 1) ? ((cyc % 4) == 0 || (cyc % 4) == 3) :
                             1'($urandom_range(1));
            enable = 1'($urandom_range(1));
            din = din + 8'd1;
            checkOutput({tag, "_ro_busy"},       busy,       1'b1);
            checkOutput({tag, "_ro_trig_reset"}, trig_reset, 1'b1);
            if (rd_if.rd_valid === 1'b1 && first_valid < 0) begin
                first_valid = cyc;
                checkOutput({tag, "_first_valid_latency"}, cyc, 2);
            end
            if (held) begin
                checkOutput({tag, "_stall_valid"}, rd_if.rd_valid, 1'b1);
                checkOutput({tag, "_stall_data"},  rd_if.rd_data,  held_data);
                checkOutput({tag, "_stall_last"},  rd_if.rd_last,  held_last);
            end
            if (rd_if.rd_valid === 1'b1 && rd_if.rd_ready) begin
                checkOutput($sformatf("%s_beat%0d_data", tag, beat + 1), rd_if.rd_data, exp_q[beat]);
                checkOutput($sformatf("%s_beat%0d_last", tag, beat + 1), rd_if.rd_last, beat == DEPTH - 1);
                if (beat == 0) first_data = rd_if.rd_data;
                last_data = rd_if.rd_data;
                beat++;
                held = 0;
            end else if (rd_if.rd_valid === 1'b1) begin
                held = 1;
                held_data = rd_if.rd_data;
                held_last = rd_if.rd_last;
            end else begin
                held = 0;
            end
            applyStimulus();
            cyc++;
        end
        checkOutput({tag, "_handshakes"}, beat, DEPTH);
        if (ready_mode == 0) checkOutput({tag, "_stream_cycles"}, cyc, DEPTH + 2);
        checkOutput({tag, "_done_pulse"},     done,           1'b1);
        checkOutput({tag, "_idle_after"},     busy,           1'b0);
        checkOutput({tag, "_valid_after"},    rd_if.rd_valid, 1'b0);
        m_phase = P_IDLE;
        rd_if.rd_ready = 1'b1;
        applyStimulus();
        checkOutput({tag, "_done_one_cycle"}, done, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=stuck expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] first_d, last_d;
        rd_if.rd_ready = 1'b1;
        #2;
        checkOutput("reset_trig_reset", trig_reset,     1'b1);
        checkOutput("reset_busy",       busy,           1'b0);
        checkOutput("reset_done",       done,           1'b0);
        checkOutput("reset_rd_valid",   rd_if.rd_valid, 1'b0);
        checkOutput("reset_rd_last",    rd_if.rd_last,  1'b0);
        checkOutput("reset_rd_data",    rd_if.rd_data,  8'h00);
`ifdef TROTRIG_CTRL_TIMEOUT_EN
        checkOutput("reset_timeout",    timeout,        1'b0);
`endif
        applyStimulus();
        applyStimulus();
        resetn = 1'b1;
        applyStimulus();
        checkState("idle");

        runCapture("s1", 4, 19, 1'b0, 100, 0, 1'b0, 0, first_d, last_d);
`ifdef TROTRIG_CTRL_TIMEOUT_EN
        checkOutput("s1_oldest", first_d, 8'h0D);
        checkOutput("s1_newest", last_d,  8'h1C);
`else
        checkOutput("s1_oldest", first_d, 8'h15);
        checkOutput("s1_newest", last_d,  8'h24);
`endif
        runCapture("s2", 4, 0, 1'b1, 100, 0, 1'b0, 0, first_d, last_d);
        runCapture("s3", 0, 0, 1'b1, 50, 0, 1'b0, 0, first_d, last_d);
        runCapture("s4", 5, 3, 1'b0, 80, 1, 1'b0, 0, first_d, last_d);
        runCapture("s5_abort", 8, 2, 1'b0, 100, 0, 1'b1, 0, first_d, last_d);
        runCapture("s5_rearm", 3, 1, 1'b0, 100, 0, 1'b0, 0, first_d, last_d);
        runCapture("s5_reset", 4, 2, 1'b0, 100, 0, 1'b0, 5, first_d, last_d);
        applyStimulus();
        checkState("s5_post_reset");
        runCapture("s5_after_reset", 6, 4, 1'b0, 100, 2, 1'b0, 0, first_d, last_d);
        for (int r = 0; r < 3; r++) begin
            runCapture($sformatf("rnd%0d", r), int'($urandom_range(15)), int'($urandom_range(10)),
                       1'b0, 70, 2, 1'b0, 0, first_d, last_d);
        end
`ifdef TROTRIG_CTRL_TIMEOUT_EN
        runCapture("s6_timeout", 4, 1000, 1'b0, 100, 0, 1'b0, 0, first_d, last_d);
        runCapture("s6_rearm", 2, 1, 1'b0, 100, 0, 1'b0, 0, first_d, last_d);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/trotrig_capture_ctrl.md
# trotrig_capture_ctrl

Capture sequencer for the `trotrig` trigger unit. It arms and releases `trotrig`, records qualified samples into a circular buffer, and stops after a programmed number of post-trigger samples. It then streams the frozen window out over a valid/ready port, oldest sample first. It sits between the sampled bus and readout logic, with `trotrig` instantiated beside it and sharing `din`/`enable`.

## Interface

Parameters:
- `DINBITS`, 8, sample width.
- `ABITS`, 6, buffer address width; `DEPTH = 2**ABITS` samples.

Ports:
- `clk` in 1: single clock.
- `resetn` in 1: asynchronous, active-low reset.
- `arm` in 1: start capture (pulse); ignored unless IDLE.
- `abort` in 1: return to IDLE from any state.
- `enable` in 1: sample qualifier; a sample is written only when high.
- `din` in DINBITS: sample data.
- `post_count` in ABITS: post-trigger samples; latched on accepted `arm`.
- `trigger` in 1: from `trotrig`.
- `trig_reset` out 1: drives `trotrig` reset, active-high.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse after the final readout beat.
- `rd_valid` out 1, `rd_ready` in 1, `rd_data` out DINBITS, `rd_last` out 1: readout stream.

## Operation

- IDLE:
  - `trig_reset`=1, no writes.
  - Accepted `arm`: clear `wptr` and `fill`, latch `post_count` as `post`, go to PREFILL.
- PREFILL:
  - Each `enable` cycle writes `din` at `wptr`, then increments `wptr` (wraps mod DEPTH) and `fill`.
  - When `fill` reaches `DEPTH-post`, go to ARMED.
  - `trig_reset` stays 1, so triggers during prefill are impossible.
- ARMED:
  - `trig_reset`=0; writes continue circularly.
  - First cycle with `trigger`=1: go to POST, load `remain=post`.
  - The write in the trigger cycle (if `enable`) is the trigger sample, the last pre-trigger entry.
- POST:
  - Each enabled write decrements `remain`.
  - On entry with `remain`=0, or after the write that makes it 0, go to READOUT. No further writes.
  - `trig_reset`=1 from POST onward.
- READOUT:
  - Read pointer starts at `wptr` (oldest entry).
  - Emits exactly DEPTH beats; `rd_last` is set on beat DEPTH.
  - After the last handshake: one-cycle `done`, then IDLE.
- Arithmetic:
  - `fill` is ABITS+1 bits wide.
  - `post` is ≤ DEPTH-1, so at least one pre-trigger sample (the trigger sample) always exists.
- `abort` has priority over every transition. Next cycle: IDLE, `rd_valid`=0, buffer contents undefined.
- `arm` together with `abort`: `abort` wins.

## Timing

- Reset values: `trig_reset`=1, `busy`=0, `done`=0, `rd_valid`=0, `rd_last`=0, `rd_data`=0, state IDLE.
- `arm` sampled at edge N: `busy`=1 after N. First write possible at N+1.
- `trig_reset` deasserts the cycle after the write that completes prefill.
- `trigger` sampled at edge T: state is POST after T.
- With `post`=0, READOUT is entered after T+1.
- RAM read latency is 1 cycle. The first `rd_valid` rises 2 cycles after READOUT entry.
- Show-ahead stream:
  - Prefetch keeps throughput at 1 beat/cycle while `rd_ready`=1.
  - `rd_data`/`rd_last` hold stable while `rd_valid` && !`rd_ready`.

## Configuration

- `TROTRIG_CTRL_TIMEOUT_EN`:
  - Defined: adds parameter `TOBITS` (default 16) and output `timeout` (1 bit, reset 0).
  - A counter runs in ARMED. After `2**TOBITS` cycles without `trigger`, the block goes to READOUT, raising `timeout` until the next accepted `arm`.
  - The window then holds the most recent DEPTH samples.
- Undefined: ARMED waits indefinitely; no `timeout` port.

## Structure

- Package `trotrig_ctrl_pkg`:
  - State enum (IDLE, PREFILL, ARMED, POST, READOUT).
  - Read latency constant (1).
  - `TOBITS` default.
- Sub-module `trotrig_capture_ram`: simple dual-port RAM, DEPTH×DINBITS, synchronous write, registered read.
- The `trotrig` instance is external. This block only drives its reset.

## Test plan

All scenarios use ABITS=4 (DEPTH 16), DINBITS=8.

1. Prefill and trigger:
   - Stimulus: `din` counts 0x00 up, `enable`=1, `post_count`=4, `arm` when `din`=0x00, `trigger` pulsed when `din`=0x20, `rd_ready`=1.
   - Response: 16 beats 0x15..0x24, beat 12 = 0x20, `rd_last` on 0x24, `done` 1 cycle later.
2. Trigger blocked during prefill:
   - Stimulus: `trigger` held 1 from `arm`.
   - Response: `trig_reset`=1 for 16-4=12 enabled samples; POST entered the first cycle `trig_reset`=0.
3. `post_count`=0 with 50% random `enable`:
   - Response: 16 prefill writes before `trig_reset` falls; the trigger sample is beat 16 (`rd_last`).
4. Backpressure:
   - Stimulus: `rd_ready` toggles 1,0,0,1 pattern.
   - Response: no beat lost or duplicated; data held while stalled; exactly 16 handshakes.
5. Abort and reset:
   - Stimulus: `abort` in POST; then `resetn`=0 mid-READOUT.
   - Response: next cycle IDLE, `rd_valid`=0, `trig_reset`=1; a new `arm` captures correctly.
6. Timeout (`TROTRIG_CTRL_TIMEOUT_EN`, TOBITS=4):
   - Stimulus: no `trigger`.
   - Response: READOUT 16 cycles after ARMED entry; `timeout`=1; last 16 samples streamed.
